// File: rtl/alu64_serial_unit.sv
// Chunk-serial 64-bit ALU: NOR / XOR / ADD / SUB computed CHUNK_W bits per cycle,
// LSB chunk first. It uses a valid/ready handshake on both the request and the result side.
module alu64_serial_unit #(
    parameter int CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic [1:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] s,
    output logic        cout
);

    localparam int NCHUNK = 64 / CHUNK_W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [63:0]        a_r;
    logic [63:0]        b_r;
    logic               cin_r;
    logic [1:0]         op_r;
    logic               carry_r;
    logic [63:0]        s_r;
    logic               cout_r;

    logic [5:0]         base;
    logic [CHUNK_W-1:0] a_ch;
    logic [CHUNK_W-1:0] b_ch;
    logic               carry_in;
    logic [CHUNK_W:0]   sum;
    logic [CHUNK_W-1:0] res_ch;

    // One chunk of the datapath; the first chunk takes its carry from the latched cin
    always_comb begin
        base     = 6'(cnt) * 6'(CHUNK_W);
        a_ch     = a_r[base +: CHUNK_W];
        b_ch     = (op_r == OP_SUB) ? ~b_r[base +: CHUNK_W] : b_r[base +: CHUNK_W];
        carry_in = (cnt == '0) ? (op_r[1] & cin_r) : carry_r;
        sum      = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK_W + 1)'(carry_in);
        case (op_r)
            OP_NOR:  res_ch = ~(a_ch | b_ch);
            OP_XOR:  res_ch = a_ch ^ b_ch;
            default: res_ch = sum[CHUNK_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            cin_r   <= 1'b0;
            op_r    <= 2'b00;
            carry_r <= 1'b0;
            s_r     <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        cin_r   <= cin;
                        op_r    <= op;
                        cnt     <= '0;
                        carry_r <= 1'b0;
                        s_r     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    s_r[base +: CHUNK_W] <= res_ch;
                    carry_r              <= op_r[1] & sum[CHUNK_W];
                    if (cnt == LAST) begin
                        cout_r <= op_r[1] & sum[CHUNK_W];
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_r;
    assign cout      = cout_r;

endmodule

// File: doc/alu64_serial_unit.md
ALU64_SERIAL_UNIT -- requirements
Module: alu64_serial_unit

Interface
REQ-001 The block SHALL have parameter CHUNK_W, default 8: bits processed per compute cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 The block SHALL derive NCHUNK = 64/CHUNK_W, the number of compute cycles per operation (default 8).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; they are the first two ports.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 a  input  64  operand A.
REQ-009 b  input  64  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 op  input  2  operation select.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 s  output  64  result.
REQ-015 cout  output  1  carry-out.

Function
REQ-016 op encoding SHALL be: 00 NOR (s = ~(a|b)), 01 XOR (s = a^b), 10 ADD ({cout,s} = a+b+cin), 11 SUB ({cout,s} = a+~b+cin); callers set cin=1 for true a-b.
REQ-017 For NOR and XOR, cout SHALL be 0.
REQ-018 The state machine SHALL have three states: IDLE, BUSY, DONE.
REQ-019 in_ready SHALL be 1 exactly when the state is IDLE. There is no overlap of requests.
REQ-020 Acceptance: on a rising edge with in_valid=1 and in_ready=1, the block SHALL latch a, b, cin and op. It SHALL then clear the chunk counter, clear the s register, and go to BUSY.
REQ-021 While the state is IDLE, changes on a, b, cin and op without a handshake SHALL have no effect.
REQ-022 In BUSY, each edge SHALL process chunk k = counter, which is bits [k*CHUNK_W +: CHUNK_W], LSB chunk first.
REQ-023 At each BUSY edge, the carry SHALL propagate from chunk k to chunk k+1 through an internal carry register. For ADD and SUB, that register SHALL be initialised from the latched cin.
REQ-024 On the edge that processes chunk NCHUNK-1, the block SHALL update s and cout and go to DONE. out_valid SHALL rise NCHUNK cycles after the accept edge, which is 8 by default.
REQ-025 out_valid SHALL be 1 exactly in DONE.
REQ-026 s and cout SHALL hold stable in DONE while out_ready=0, with no limit on the stall.
REQ-027 On an edge with out_valid=1 and out_ready=1, the block SHALL go to IDLE. The next request SHALL be accepted no earlier than the following edge.
REQ-028 s and cout SHALL keep their last values in IDLE. Partial s values SHALL be visible during BUSY but are not valid.
REQ-029 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-030 Counter wrap: the counter SHALL be log2(NCHUNK) bits wide and SHALL never be used past NCHUNK-1. For CHUNK_W=64, BUSY SHALL last exactly one cycle.

Reset
REQ-031 rst=1 at an edge SHALL force the state to IDLE, the counter to 0, s to 0, cout to 0, out_valid to 0, the carry register to 0, and the latched operands to 0.
REQ-032 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-033 Reset SHALL have priority over any handshake in the same cycle.
REQ-034 Reset in BUSY or DONE SHALL abandon the operation; no result SHALL be delivered for it.
REQ-035 A request presented while rst=1 SHALL NOT be accepted.

Verification
REQ-036 ADD with a=FFFF_FFFF_FFFF_FFFF, b=0, cin=0, out_ready=1 -> after 8 cycles: s=FFFF_FFFF_FFFF_FFFF, cout=0, out_valid for 1 cycle.
REQ-037 ADD with a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> s=0, cout=1; this checks carry ripple across all 8 chunks.
REQ-038 SUB with a=5, b=3, cin=1 -> s=2, cout=1. SUB with a=3, b=5, cin=1 -> s=FFFF_FFFF_FFFF_FFFE, cout=0.
REQ-039 XOR with a=F0F0_F0F0_F0F0_F0F0, b=FFFF_0000_FFFF_0000 -> s=0F0F_F0F0_0F0F_F0F0, cout=0. NOR with a=0, b=0 -> s=FFFF_FFFF_FFFF_FFFF, cout=0.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE -> s, cout and out_valid stay stable and in_ready=0. Then raise out_ready -> IDLE and in_ready=1 on the next cycle. A back-to-back second request is then accepted.
REQ-041 Assert rst for 1 cycle in BUSY at counter=4 -> next cycle: IDLE, s=0, cout=0, out_valid=0, in_ready=1. No stale result appears afterwards.
